load_store_mem_access_stage: RTL and testbench
==============================================

// Module: load_store_mem_access_stage
// PURPOSE
// - Stage directly downstream of load/store address generation: consumes the final memory address,
//   store data and load/store controls, runs the data-memory req/ack handshake, and writes load results back.
// - Sequences LDM/STM as one beat per register in the list, lowest register first, address +4 per beat.
// - Single issue: accepts a new instruction only when idle; stalls upstream via ready_out.
// PARAMETERS
// - ADDR_W      32  memory address width
// - DATA_W      32  memory/register data width
// - REG_ADDR_W  4   register file index width
// - TAG_W       4   instruction tag width, carried through to writeback
// - REG_LIST_W  16  LDM/STM register-list width (one bit per register)
// PORTS
// - clk_in           in   1           single clock, rising edge
// - reset_in         in   1           asynchronous, active-low reset
// - valid_in         in   1           upstream presents an instruction
// - ready_out        out  1           stage idle; transfer when valid_in && ready_out
// - instr_exec_in    in   1           condition passed; 0 = consume with no side effects
// - instr_tag_in     in   TAG_W       tag of incoming instruction
// - addr_in          in   ADDR_W      computed address (start address for LDM/STM)
// - is_load_in       in   1           1 = load, 0 = store
// - size_in          in   2           00 byte, 01 halfword, 10 word (11 treated as word)
// - rd_addr_in       in   REG_ADDR_W  destination (load) register for single transfers
// - str_data_in      in   DATA_W      store data for single transfers
// - ld_str_multiple_in in 1           1 = LDM/STM using reg_list_in (size forced to word)
// - reg_list_in      in   REG_LIST_W  LDM/STM register list
// - stm_rd_addr_out  out  REG_ADDR_W  register read index for current STM beat
// - stm_rd_data_in   in   DATA_W      combinational read data for stm_rd_addr_out
// - mem_req_out      out  1           memory request, held until mem_ack_in
// - mem_we_out       out  1           1 = write
// - mem_addr_out     out  ADDR_W      word-aligned address {addr[ADDR_W-1:2],2'b00}
// - mem_be_out       out  4           byte-lane enables
// - mem_wdata_out    out  DATA_W      write data, replicated across lanes for byte/half
// - mem_ack_in       in   1           memory completes current request this cycle
// - mem_rdata_in     in   DATA_W      read data, valid with mem_ack_in
// - wb_valid_out     out  1           one-cycle writeback pulse
// - wb_addr_out      out  REG_ADDR_W  writeback register
// - wb_data_out      out  DATA_W      aligned, zero-extended load data
// - wb_tag_out       out  TAG_W       tag of producing instruction
// BEHAVIOUR
// - Reset (reset_in=0, async): state IDLE; every output register 0; ready_out=1 once reset released.
// - States: IDLE, ACCESS, MULTI. ready_out = (state==IDLE).
// - IDLE: on accept, instr_exec_in=0 -> stay IDLE, nothing issued; multiple with reg_list_in==0 -> no-op, stay IDLE;
//   single -> capture all inputs, go ACCESS; multiple -> capture list/address/direction, go MULTI.
// - ACCESS: mem_req_out=1 with addr/we/be/wdata stable until mem_ack_in. On ack: load -> wb_valid_out=1 next cycle
//   (rd, tag, aligned data); store -> no writeback; go IDLE. Min latency: accept T0, req T1, ack T1, wb T2, ready T2.
// - MULTI: current reg = lowest set bit of remaining list; stm_rd_addr_out = that reg; each beat is a full req/ack;
//   on ack clear that bit, addr += 4 (mod 2^ADDR_W, wraps 32'hFFFF_FFFC -> 0), load beats pulse wb next cycle;
//   go IDLE on ack of last set bit. Back-to-back beats: next request asserted the cycle after ack.
// - Lanes: byte be=1<<addr[1:0], half be=addr[1]?4'b1100:4'b0011 (addr[0] ignored), word be=4'b1111 (addr[1:0] ignored).
// - Load data: lane selected by address, zero-extended; word passed unchanged.
// - mem_ack_in while mem_req_out=0 is ignored. valid_in while busy is not accepted (no capture).
// - Reset mid-operation: request dropped immediately, pending wb pulse cancelled, list cleared.
// STRUCTURE
// - Shared define file load_store_mem_access_stage_define.v: state encodings, size encodings, widths.
// - One sub-module mem_lane_align (combinational): be generation, store lane replication, load extract/extend.
// - Lowest-set-bit priority encoder inline in this module.
// TESTING
// - Single LDR word @0x100, rdata 0xDEADBEEF, ack in 1st req cycle -> wb r3=0xDEADBEEF at T2, ready at T2.
// - LDRB @0x103, rdata 0xAB00_0000 -> be=4'b1000, wb data 0x0000_00AB; STRH @0x102 data 0x1234 -> be 1100, wdata 0x12341234.
// - STR with mem_ack_in delayed 3 cycles -> req/addr/wdata stable 4 cycles, ready_out low throughout, no wb.
// - LDM list 16'h8005 @0x200 -> beats r0@0x200, r2@0x204, r15@0x208, three wb pulses in that order.
// - instr_exec_in=0 LDR, and LDM with empty list -> no mem_req_out, no wb, ready_out stays 1.
// - reset_in low during 2nd STM beat -> mem_req_out=0 immediately, IDLE after release, no stale beat issued.

Source files
------------

// File: rtl/load_store_mem_access_stage_pkg.sv
// Shared encodings for the load/store memory-access stage: FSM states and
// transfer-size codes.
package load_store_mem_access_stage_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_MULTI  = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/load_store_mem_access_stage_lane_align.sv
// Byte-lane steering for a 32-bit data memory: byte enables, store-data replication
// and load-data extraction with zero extension.
module mem_lane_align
    import load_store_mem_access_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] ld_raw,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] st_lanes,
    output logic [DATA_W-1:0] ld_data
);

    logic [DATA_W-1:0] ld_shift_s;

    // Move the addressed byte/halfword down to bit 0 before truncation.
    always_comb begin
        ld_shift_s = ld_raw >> {addr_lo, 3'b000};
    end

    // Lane enables, store replication and load extraction per access size; size 11 acts as word.
    always_comb begin
        be       = 4'b1111;
        st_lanes = st_data;
        ld_data  = ld_raw;
        case (size)
            SIZE_BYTE: begin
                be       = 4'b0001 << addr_lo;
                st_lanes = {4{st_data[7:0]}};
                ld_data  = {{(DATA_W-8){1'b0}}, ld_shift_s[7:0]};
            end
            SIZE_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
                ld_data  = addr_lo[1] ? {{(DATA_W-16){1'b0}}, ld_raw[31:16]}
                                      : {{(DATA_W-16){1'b0}}, ld_raw[15:0]};
            end
            default: begin
                be       = 4'b1111;
                st_lanes = st_data;
                ld_data  = ld_raw;
            end
        endcase
    end

endmodule

// File: rtl/load_store_mem_access_stage.sv
// Memory-access stage: runs the data-memory req/ack handshake for single and
// multiple (LDM/STM) transfers and writes load results back one pulse per beat.
module load_store_mem_access_stage
    import load_store_mem_access_stage_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int TAG_W      = 4,
    parameter int REG_LIST_W = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  instr_exec_in,
    input  logic [TAG_W-1:0]      instr_tag_in,
    input  logic [ADDR_W-1:0]     addr_in,
    input  logic                  is_load_in,
    input  logic [1:0]            size_in,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    input  logic [DATA_W-1:0]     str_data_in,
    input  logic                  ld_str_multiple_in,
    input  logic [REG_LIST_W-1:0] reg_list_in,
    output logic [REG_ADDR_W-1:0] stm_rd_addr_out,
    input  logic [DATA_W-1:0]     stm_rd_data_in,
    output logic                  mem_req_out,
    output logic                  mem_we_out,
    output logic [ADDR_W-1:0]     mem_addr_out,
    output logic [3:0]            mem_be_out,
    output logic [DATA_W-1:0]     mem_wdata_out,
    input  logic                  mem_ack_in,
    input  logic [DATA_W-1:0]     mem_rdata_in,
    output logic                  wb_valid_out,
    output logic [REG_ADDR_W-1:0] wb_addr_out,
    output logic [DATA_W-1:0]     wb_data_out,
    output logic [TAG_W-1:0]      wb_tag_out
);

    logic [1:0]            state_r;
    logic [ADDR_W-1:0]     addr_r;
    logic                  is_load_r;
    logic [1:0]            size_r;
    logic [REG_ADDR_W-1:0] rd_r;
    logic [DATA_W-1:0]     str_data_r;
    logic [TAG_W-1:0]      tag_r;
    logic [REG_LIST_W-1:0] list_r;
    logic                  mem_req_r;
    logic                  wb_valid_r;
    logic [REG_ADDR_W-1:0] wb_addr_r;
    logic [DATA_W-1:0]     wb_data_r;
    logic [TAG_W-1:0]      wb_tag_r;

    logic                  accept_s;
    logic                  ack_s;
    logic [REG_ADDR_W-1:0] cur_reg_s;
    logic [REG_LIST_W-1:0] list_next_s;
    logic [DATA_W-1:0]     st_src_s;
    logic [3:0]            be_s;
    logic [DATA_W-1:0]     st_lanes_s;
    logic [DATA_W-1:0]     ld_data_s;

    // Handshake qualifiers; an ack with no request outstanding is ignored.
    always_comb begin
        accept_s = valid_in && (state_r == ST_IDLE);
        ack_s    = mem_ack_in && mem_req_r;
    end

    // Lowest-set-bit priority encoder: scanning high to low leaves the lowest index.
    always_comb begin
        cur_reg_s = {REG_ADDR_W{1'b0}};
        for (int i = REG_LIST_W - 1; i >= 0; i--) begin
            cur_reg_s = list_r[i] ? REG_ADDR_W'(i) : cur_reg_s;
        end
        list_next_s = list_r & ~({{(REG_LIST_W-1){1'b0}}, 1'b1} << cur_reg_s);
    end

    // STM beats take their data straight from the register file read port.
    always_comb begin
        st_src_s = (state_r == ST_MULTI) ? stm_rd_data_in : str_data_r;
    end

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .addr_lo  (addr_r[1:0]),
        .size     (size_r),
        .st_data  (st_src_s),
        .ld_raw   (mem_rdata_in),
        .be       (be_s),
        .st_lanes (st_lanes_s),
        .ld_data  (ld_data_s)
    );

    // Control FSM, captured instruction fields and writeback registers.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            is_load_r  <= 1'b0;
            size_r     <= 2'b00;
            rd_r       <= {REG_ADDR_W{1'b0}};
            str_data_r <= {DATA_W{1'b0}};
            tag_r      <= {TAG_W{1'b0}};
            list_r     <= {REG_LIST_W{1'b0}};
            mem_req_r  <= 1'b0;
            wb_valid_r <= 1'b0;
            wb_addr_r  <= {REG_ADDR_W{1'b0}};
            wb_data_r  <= {DATA_W{1'b0}};
            wb_tag_r   <= {TAG_W{1'b0}};
        end else begin
            wb_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && instr_exec_in) begin
                        addr_r    <= addr_in;
                        is_load_r <= is_load_in;
                        tag_r     <= instr_tag_in;
                        if (ld_str_multiple_in) begin
                            // An empty register list completes as a no-op.
                            if (reg_list_in != {REG_LIST_W{1'b0}}) begin
                                list_r    <= reg_list_in;
                                size_r    <= SIZE_WORD;
                                mem_req_r <= 1'b1;
                                state_r   <= ST_MULTI;
                            end else begin
                                state_r   <= ST_IDLE;
                            end
                        end else begin
                            size_r     <= size_in;
                            rd_r       <= rd_addr_in;
                            str_data_r <= str_data_in;
                            mem_req_r  <= 1'b1;
                            state_r    <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (ack_s) begin
                        mem_req_r <= 1'b0;
                        state_r   <= ST_IDLE;
                        if (is_load_r) begin
                            wb_valid_r <= 1'b1;
                            wb_addr_r  <= rd_r;
                            wb_data_r  <= ld_data_s;
                            wb_tag_r   <= tag_r;
                        end
                    end
                end
                ST_MULTI: begin
                    if (ack_s) begin
                        list_r <= list_next_s;
                        addr_r <= addr_r + ADDR_W'(3'd4);
                        if (is_load_r) begin
                            wb_valid_r <= 1'b1;
                            wb_addr_r  <= cur_reg_s;
                            wb_data_r  <= ld_data_s;
                            wb_tag_r   <= tag_r;
                        end
                        // Request stays high into the next beat unless this was the last register.
                        if (list_next_s == {REG_LIST_W{1'b0}}) begin
                            mem_req_r <= 1'b0;
                            state_r   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    list_r    <= {REG_LIST_W{1'b0}};
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs are derived from registers and held at zero between requests.
    always_comb begin
        ready_out       = (state_r == ST_IDLE);
        stm_rd_addr_out = (state_r == ST_MULTI) ? cur_reg_s : {REG_ADDR_W{1'b0}};
        mem_req_out     = mem_req_r;
        mem_we_out      = mem_req_r & ~is_load_r;
        mem_addr_out    = mem_req_r ? {addr_r[ADDR_W-1:2], 2'b00} : {ADDR_W{1'b0}};
        mem_be_out      = mem_req_r ? be_s : 4'b0000;
        mem_wdata_out   = (mem_req_r && !is_load_r) ? st_lanes_s : {DATA_W{1'b0}};
        wb_valid_out    = wb_valid_r;
        wb_addr_out     = wb_addr_r;
        wb_data_out     = wb_data_r;
        wb_tag_out      = wb_tag_r;
    end

endmodule

// File: tb/tb_load_store_mem_access_stage.sv
// Directed bench for the memory-access stage; expected writebacks are queued when
// the responder completes a load and checked as the stage emits them.
module tb_load_store_mem_access_stage;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
        logic [3:0]  tag;
    } wb_exp_t;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        instr_exec_in = 1'b0;
    logic [3:0]  instr_tag_in = 4'd0;
    logic [31:0] addr_in = 32'd0;
    logic        is_load_in = 1'b0;
    logic [1:0]  size_in = 2'd0;
    logic [3:0]  rd_addr_in = 4'd0;
    logic [31:0] str_data_in = 32'd0;
    logic        ld_str_multiple_in = 1'b0;
    logic [15:0] reg_list_in = 16'd0;
    logic [3:0]  stm_rd_addr_out;
    logic [31:0] stm_rd_data_in;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [3:0]  mem_be_out;
    logic [31:0] mem_wdata_out;
    logic        mem_ack_in = 1'b0;
    logic [31:0] mem_rdata_in = 32'd0;
    logic        wb_valid_out;
    logic [3:0]  wb_addr_out;
    logic [31:0] wb_data_out;
    logic [3:0]  wb_tag_out;

    int checks = 0;
    int errors = 0;
    wb_exp_t exp_q[$];

    // Register file model: each register reads as 0x1000_0000 plus its index.
    assign stm_rd_data_in = 32'h1000_0000 | {28'h0, stm_rd_addr_out};

    load_store_mem_access_stage dut (
        .clk_in             (clk_in),
        .reset_in           (reset_in),
        .valid_in           (valid_in),
        .ready_out          (ready_out),
        .instr_exec_in      (instr_exec_in),
        .instr_tag_in       (instr_tag_in),
        .addr_in            (addr_in),
        .is_load_in         (is_load_in),
        .size_in            (size_in),
        .rd_addr_in         (rd_addr_in),
        .str_data_in        (str_data_in),
        .ld_str_multiple_in (ld_str_multiple_in),
        .reg_list_in        (reg_list_in),
        .stm_rd_addr_out    (stm_rd_addr_out),
        .stm_rd_data_in     (stm_rd_data_in),
        .mem_req_out        (mem_req_out),
        .mem_we_out         (mem_we_out),
        .mem_addr_out       (mem_addr_out),
        .mem_be_out         (mem_be_out),
        .mem_wdata_out      (mem_wdata_out),
        .mem_ack_in         (mem_ack_in),
        .mem_rdata_in       (mem_rdata_in),
        .wb_valid_out       (wb_valid_out),
        .wb_addr_out        (wb_addr_out),
        .wb_data_out        (wb_data_out),
        .wb_tag_out         (wb_tag_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Writeback monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (reset_in && wb_valid_out) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", {31'd0, wb_valid_out}, 32'd0);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                chk("wb_addr", {28'd0, wb_addr_out}, {28'd0, e.rd});
                chk("wb_data", wb_data_out, e.data);
                chk("wb_tag", {28'd0, wb_tag_out}, {28'd0, e.tag});
            end
        end
    end

    task automatic issue(input logic exec, input logic [3:0] tag, input logic [31:0] addr,
                         input logic ld, input logic [1:0] size, input logic [3:0] rd,
                         input logic [31:0] sdata, input logic mult, input logic [15:0] list);
        chk("ready_before_issue", {31'd0, ready_out}, 32'd1);
        valid_in = 1'b1; instr_exec_in = exec; instr_tag_in = tag; addr_in = addr;
        is_load_in = ld; size_in = size; rd_addr_in = rd; str_data_in = sdata;
        ld_str_multiple_in = mult; reg_list_in = list;
        @(negedge clk_in);
        valid_in = 1'b0;
    endtask

    // Serve one beat: check the request stays stable for delay+1 cycles, ack on the last.
    task automatic serve(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic chk_stm, input logic [3:0] stm_reg,
                         input logic [31:0] rdata, input int delay, input logic push,
                         input wb_exp_t e);
        int waited = 0;
        while (mem_req_out !== 1'b1 && waited < 16) begin
            @(negedge clk_in);
            waited++;
        end
        chk("req_timeout", {31'd0, mem_req_out}, 32'd1);
        for (int k = 0; k <= delay; k++) begin
            chk("mem_req", {31'd0, mem_req_out}, 32'd1);
            chk("mem_we", {31'd0, mem_we_out}, {31'd0, we});
            chk("mem_addr", mem_addr_out, addr);
            chk("mem_be", {28'd0, mem_be_out}, {28'd0, be});
            chk("ready_busy", {31'd0, ready_out}, 32'd0);
            if (we) chk("mem_wdata", mem_wdata_out, wdata);
            if (chk_stm) chk("stm_rd_addr", {28'd0, stm_rd_addr_out}, {28'd0, stm_reg});
            if (k == delay) begin
                mem_ack_in = 1'b1;
                mem_rdata_in = rdata;
                if (push) exp_q.push_back(e);
            end
            @(negedge clk_in);
        end
        mem_ack_in = 1'b0;
        mem_rdata_in = 32'h0;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_req"}, {31'd0, mem_req_out}, 32'd0);
            chk({tag, "_ready"}, {31'd0, ready_out}, 32'd1);
            @(negedge clk_in);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_exp_t e;
        wb_exp_t none;
        none.rd = 4'd0; none.data = 32'd0; none.tag = 4'd0;

        // Reset state
        repeat (2) @(negedge clk_in);
        reset_in = 1'b1;
        chk("rst_ready", {31'd0, ready_out}, 32'd1);
        chk("rst_req", {31'd0, mem_req_out}, 32'd0);
        chk("rst_be", {28'd0, mem_be_out}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid_out}, 32'd0);
        chk("rst_wb_data", wb_data_out, 32'd0);
        @(negedge clk_in);

        // LDR word @0x100, ack in first request cycle; wb and ready at T2
        issue(1'b1, 4'd5, 32'h100, 1'b1, 2'b10, 4'd3, 32'd0, 1'b0, 16'd0);
        e.rd = 4'd3; e.data = 32'hDEAD_BEEF; e.tag = 4'd5;
        serve(1'b0, 32'h100, 4'b1111, 32'd0, 1'b0, 4'd0, 32'hDEAD_BEEF, 0, 1'b1, e);
        chk("ldr_wb_T2", {31'd0, wb_valid_out}, 32'd1);
        chk("ldr_ready_T2", {31'd0, ready_out}, 32'd1);
        chk("ldr_req_T2", {31'd0, mem_req_out}, 32'd0);
        @(negedge clk_in);

        // LDRB @0x103
        issue(1'b1, 4'd6, 32'h103, 1'b1, 2'b00, 4'd7, 32'd0, 1'b0, 16'd0);
        e.rd = 4'd7; e.data = 32'h0000_00AB; e.tag = 4'd6;
        serve(1'b0, 32'h100, 4'b1000, 32'd0, 1'b0, 4'd0, 32'hAB00_0000, 0, 1'b1, e);

        // LDRH @0x101: addr[0] ignored, low half
        issue(1'b1, 4'd1, 32'h101, 1'b1, 2'b01, 4'd4, 32'd0, 1'b0, 16'd0);
        e.rd = 4'd4; e.data = 32'h0000_7788; e.tag = 4'd1;
        serve(1'b0, 32'h100, 4'b0011, 32'd0, 1'b0, 4'd0, 32'h5566_7788, 0, 1'b1, e);

        // STRH @0x102 data 0x1234
        issue(1'b1, 4'd2, 32'h102, 1'b0, 2'b01, 4'd0, 32'hFFFF_1234, 1'b0, 16'd0);
        serve(1'b1, 32'h100, 4'b1100, 32'h1234_1234, 1'b0, 4'd0, 32'd0, 0, 1'b0, none);

        // STR with 3-cycle ack delay; a second instruction offered while busy must be ignored
        issue(1'b1, 4'd8, 32'h43, 1'b0, 2'b11, 4'd0, 32'hCAFE_F00D, 1'b0, 16'd0);
        valid_in = 1'b1; instr_exec_in = 1'b1; addr_in = 32'h500; is_load_in = 1'b1;
        size_in = 2'b10; rd_addr_in = 4'd9; ld_str_multiple_in = 1'b0;
        serve(1'b1, 32'h40, 4'b1111, 32'hCAFE_F00D, 1'b0, 4'd0, 32'd0, 3, 1'b0, none);
        valid_in = 1'b0;
        idle_check("busy_ignored", 3);

        // Condition-failed LDR and empty-list LDM are consumed silently
        issue(1'b0, 4'd3, 32'h100, 1'b1, 2'b10, 4'd5, 32'd0, 1'b0, 16'd0);
        idle_check("noexec", 3);
        issue(1'b1, 4'd3, 32'h100, 1'b1, 2'b10, 4'd0, 32'd0, 1'b1, 16'h0000);
        idle_check("empty_ldm", 3);

        // LDM list 0x8005 @0x200: r0, r2, r15 back-to-back
        issue(1'b1, 4'd9, 32'h200, 1'b1, 2'b00, 4'd0, 32'd0, 1'b1, 16'h8005);
        e.tag = 4'd9;
        e.rd = 4'd0;  e.data = 32'hA0A0_0000;
        serve(1'b0, 32'h200, 4'b1111, 32'd0, 1'b1, 4'd0, e.data, 0, 1'b1, e);
        e.rd = 4'd2;  e.data = 32'hA2A2_0002;
        serve(1'b0, 32'h204, 4'b1111, 32'd0, 1'b1, 4'd2, e.data, 1, 1'b1, e);
        e.rd = 4'd15; e.data = 32'hAFAF_000F;
        serve(1'b0, 32'h208, 4'b1111, 32'd0, 1'b1, 4'd15, e.data, 0, 1'b1, e);
        idle_check("ldm_done", 2);

        // LDM address wrap from 0xFFFF_FFFC to 0
        issue(1'b1, 4'd2, 32'hFFFF_FFFC, 1'b1, 2'b00, 4'd0, 32'd0, 1'b1, 16'h0003);
        e.tag = 4'd2;
        e.rd = 4'd0; e.data = 32'h0000_0011;
        serve(1'b0, 32'hFFFF_FFFC, 4'b1111, 32'd0, 1'b1, 4'd0, e.data, 0, 1'b1, e);
        e.rd = 4'd1; e.data = 32'h0000_0022;
        serve(1'b0, 32'h0000_0000, 4'b1111, 32'd0, 1'b1, 4'd1, e.data, 0, 1'b1, e);
        idle_check("wrap_done", 2);

        // STM r1,r2 @0x300 with reset asserted during the second beat
        issue(1'b1, 4'd4, 32'h300, 1'b0, 2'b00, 4'd0, 32'd0, 1'b1, 16'h0006);
        serve(1'b1, 32'h300, 4'b1111, 32'h1000_0001, 1'b1, 4'd1, 32'd0, 0, 1'b0, none);
        chk("stm2_req", {31'd0, mem_req_out}, 32'd1);
        chk("stm2_addr", mem_addr_out, 32'h304);
        chk("stm2_wdata", mem_wdata_out, 32'h1000_0002);
        #2 reset_in = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, mem_req_out}, 32'd0);
        chk("rst_mid_wb", {31'd0, wb_valid_out}, 32'd0);
        @(negedge clk_in);
        reset_in = 1'b1;
        idle_check("after_rst", 4);

        chk("wb_pending", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
